// File: rtl/wwdg_refresh_ctrl.sv
// ============================================================================
//  Module      : wwdg_refresh_ctrl
//  Description : Wishbone-style bus master that configures, arms and services
//                a Window Watchdog. It reloads the counter only inside the
//                legal window, and only after a software heartbeat.
//  Option      : define WWDG_CTRL_EWI_CLR_EN to add early-wakeup interrupt
//                clearing (wwdg_ewi input, ewi_cnt output, ST register write)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wwdg_refresh_ctrl #(
    parameter int              DW          = 10,
    parameter logic [31:0]     BASE_ADR    = 32'h0110_0000,
    parameter logic [DW-1:0]   CFG_VAL     = 10'b00_0111_1111,
    parameter logic [6:0]      RELOAD_VAL  = 7'h7F,
    parameter int              POLL_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          kick_req,
`ifdef WWDG_CTRL_EWI_CLR_EN
    input  logic          wwdg_ewi,
    output logic [7:0]    ewi_cnt,
`endif
    output logic [DW-1:0] dat_m2s,
    output logic [31:0]   adr_m2s,
    output logic          cyc_m2s,
    output logic          stb_m2s,
    output logic          we_m2s,
    input  logic [DW-1:0] dat_s2m,
    input  logic          ack_s2m,
    output logic          armed,
    output logic [15:0]   refresh_cnt,
    output logic          missed_kick,
    output logic          busy
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_wr_cfg = 3'd1;
    localparam logic [2:0] c_st_wr_arm = 3'd2;
    localparam logic [2:0] c_st_wait   = 3'd3;
    localparam logic [2:0] c_st_rd_cr  = 3'd4;
    localparam logic [2:0] c_st_eval   = 3'd5;
    localparam logic [2:0] c_st_wr_ref = 3'd6;
`ifdef WWDG_CTRL_EWI_CLR_EN
    localparam logic [2:0] c_st_wr_st  = 3'd7;
`endif

    localparam logic [DW-1:0] c_reload_dat = DW'({1'b1, RELOAD_VAL});
    localparam logic [15:0]   c_poll_last  = 16'(POLL_CYCLES - 1);

    logic [2:0]    r_state;
    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic [31:0]   r_adr;
    logic [DW-1:0] r_dat;
    logic          r_armed;
    logic [15:0]   r_refresh_cnt;
    logic          r_missed;
    logic          r_kick_pending;
    logic [15:0]   r_poll_cnt;
    logic [6:0]    r_w;
    logic [6:0]    r_t;

    logic          w_we;
    logic [31:0]   w_adr;
    logic [DW-1:0] w_dat;
    logic [2:0]    w_ack_state;
    logic          w_ref_ack;
    logic          w_in_window;
    logic          w_unused_dat;

    // Only T (bits 6:0) of the control register is of interest
    assign w_unused_dat = &{1'b0, dat_s2m[DW-1:7]};

    assign w_ref_ack   = (r_state == c_st_wr_ref) && r_cyc && ack_s2m;
    assign w_in_window = (r_t <= r_w);

`ifdef WWDG_CTRL_EWI_CLR_EN
    logic       r_ewi_d;
    logic       r_ewi_pending;
    logic [7:0] r_ewi_cnt;
    logic       w_st_ack;

    assign w_st_ack = (r_state == c_st_wr_st) && r_cyc && ack_s2m;
    assign ewi_cnt  = r_ewi_cnt;

    // EWI edge detect; a new edge beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ewi_d       <= 1'b0;
            r_ewi_pending <= 1'b0;
            r_ewi_cnt     <= 8'd0;
        end else begin
            r_ewi_d <= wwdg_ewi;
            if (wwdg_ewi && !r_ewi_d) begin
                r_ewi_pending <= 1'b1;
            end else if (w_st_ack) begin
                r_ewi_pending <= 1'b0;
            end
            if (w_st_ack) begin
                r_ewi_cnt <= r_ewi_cnt + 8'd1;
            end
        end
    end
`endif

    // Address/data/direction of the transaction owned by the current state,
    // plus where to go once it is acknowledged
    always_comb begin
        w_we        = 1'b1;
        w_adr       = BASE_ADR;
        w_dat       = c_reload_dat;
        w_ack_state = c_st_wait;
        case (r_state)
            c_st_wr_cfg: begin
                w_adr       = BASE_ADR + 32'd4;
                w_dat       = CFG_VAL;
                w_ack_state = c_st_wr_arm;
            end
            c_st_rd_cr: begin
                w_we        = 1'b0;
                w_dat       = '0;
                w_ack_state = c_st_eval;
            end
`ifdef WWDG_CTRL_EWI_CLR_EN
            c_st_wr_st: begin
                w_adr = BASE_ADR + 32'd8;
                w_dat = '0;
            end
`endif
            default: ;
        endcase
        // Losing enable mid-transaction: finish the cycle, then park in IDLE
        if (!enable) begin
            w_ack_state = c_st_idle;
        end
    end

    // Heartbeat latch; a kick arriving on the refresh ack keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kick_pending <= 1'b0;
        end else if (kick_req) begin
            r_kick_pending <= 1'b1;
        end else if (w_ref_ack) begin
            r_kick_pending <= 1'b0;
        end
    end

    // Main sequencer: start-up, polling, window evaluation and bus handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= 32'd0;
            r_dat         <= '0;
            r_armed       <= 1'b0;
            r_refresh_cnt <= 16'd0;
            r_missed      <= 1'b0;
            r_poll_cnt    <= 16'd0;
            r_w           <= 7'd0;
            r_t           <= 7'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (enable) begin
                        r_state <= r_armed ? c_st_wait : c_st_wr_cfg;
                    end
                end
                c_st_wait: begin
                    if (!enable) begin
                        r_state    <= c_st_idle;
                        r_poll_cnt <= 16'd0;
`ifdef WWDG_CTRL_EWI_CLR_EN
                    end else if (r_ewi_pending) begin
                        r_state    <= c_st_wr_st;
                        r_poll_cnt <= 16'd0;
`endif
                    end else if (r_poll_cnt == c_poll_last) begin
                        r_state    <= c_st_rd_cr;
                        r_poll_cnt <= 16'd0;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                    end
                end
                c_st_eval: begin
                    if (w_in_window && r_t[6] && r_kick_pending) begin
                        r_state <= c_st_wr_ref;
                    end else begin
                        if (w_in_window && !r_kick_pending) begin
                            r_missed <= 1'b1;
                        end
                        r_state <= c_st_wait;
                    end
                end
`ifdef WWDG_CTRL_EWI_CLR_EN
                c_st_wr_cfg, c_st_wr_arm, c_st_rd_cr, c_st_wr_ref, c_st_wr_st: begin
`else
                c_st_wr_cfg, c_st_wr_arm, c_st_rd_cr, c_st_wr_ref: begin
`endif
                    // cyc low on entry guarantees an idle clock between cycles
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_we  <= w_we;
                        r_adr <= w_adr;
                        r_dat <= w_dat;
                    end else if (ack_s2m) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_adr   <= 32'd0;
                        r_dat   <= '0;
                        r_state <= w_ack_state;
                        if (r_state == c_st_wr_cfg) begin
                            r_w <= CFG_VAL[6:0];
                        end
                        if (r_state == c_st_wr_arm) begin
                            r_armed <= 1'b1;
                        end
                        if (r_state == c_st_rd_cr) begin
                            r_t <= dat_s2m[6:0];
                        end
                        if (r_state == c_st_wr_ref) begin
                            r_refresh_cnt <= r_refresh_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign dat_m2s     = r_dat;
    assign adr_m2s     = r_adr;
    assign cyc_m2s     = r_cyc;
    assign stb_m2s     = r_stb;
    assign we_m2s      = r_we;
    assign armed       = r_armed;
    assign refresh_cnt = r_refresh_cnt;
    assign missed_kick = r_missed;
    assign busy        = r_cyc;

    // Bus protocol sanity
    a_ack_in_cycle: assert property (@(posedge clk) disable iff (rst) ack_s2m |-> r_cyc);
    a_stb_in_cycle: assert property (@(posedge clk) disable iff (rst) r_stb |-> r_cyc);

endmodule

`default_nettype wire

// File: tb/tb_wwdg_refresh_ctrl.sv
// ============================================================================
//  Module      : tb_wwdg_refresh_ctrl
//  Description : Directed self-checking bench for wwdg_refresh_ctrl with a
//                small watchdog slave model that logs every transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wwdg_refresh_ctrl;

    localparam logic [31:0] c_cr  = 32'h0110_0000;
    localparam logic [31:0] c_cfg = 32'h0110_0004;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        kick_req;
    logic [9:0]  dat_m2s;
    logic [31:0] adr_m2s;
    logic        cyc_m2s;
    logic        stb_m2s;
    logic        we_m2s;
    logic [9:0]  dat_s2m;
    logic        ack_s2m;
    logic        armed;
    logic [15:0] refresh_cnt;
    logic        missed_kick;
    logic        busy;
`ifdef WWDG_CTRL_EWI_CLR_EN
    logic        wwdg_ewi;
    logic [7:0]  ewi_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ws;
    int          n_wr    = 0;
    logic        kick_at_ref;
    logic        slave_kicked;
    logic [31:0] tx_adr[$];
    logic [31:0] tx_dat[$];
    logic [31:0] tx_we[$];
    int          nt;

    wwdg_refresh_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .kick_req    (kick_req),
`ifdef WWDG_CTRL_EWI_CLR_EN
        .wwdg_ewi    (wwdg_ewi),
        .ewi_cnt     (ewi_cnt),
`endif
        .dat_m2s     (dat_m2s),
        .adr_m2s     (adr_m2s),
        .cyc_m2s     (cyc_m2s),
        .stb_m2s     (stb_m2s),
        .we_m2s      (we_m2s),
        .dat_s2m     (dat_s2m),
        .ack_s2m     (ack_s2m),
        .armed       (armed),
        .refresh_cnt (refresh_cnt),
        .missed_kick (missed_kick),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_kick();
        @(negedge clk);
        kick_req = 1'b1;
        @(negedge clk);
        kick_req = 1'b0;
    endtask

    // Watchdog slave: ws wait states, then a one-clock ack; logs each access
    initial begin : slave
        logic        in_tx;
        int          wcnt;
        logic [31:0] a0;
        logic [9:0]  d0;
        logic        w0;
        ack_s2m      = 1'b0;
        slave_kicked = 1'b0;
        in_tx        = 1'b0;
        wcnt         = 0;
        forever begin
            @(negedge clk);
            if (slave_kicked) begin
                kick_req     = 1'b0;
                slave_kicked = 1'b0;
            end
            if (rst) begin
                ack_s2m = 1'b0;
                in_tx   = 1'b0;
            end else if (ack_s2m) begin
                ack_s2m = 1'b0;
                in_tx   = 1'b0;
            end else if (cyc_m2s && stb_m2s) begin
                if (!in_tx) begin
                    in_tx = 1'b1;
                    wcnt  = 0;
                    a0    = adr_m2s;
                    d0    = dat_m2s;
                    w0    = we_m2s;
                end
                if (wcnt >= ws) begin
                    ack_s2m = 1'b1;
                    chk("stable_adr", adr_m2s, a0);
                    chk("stable_dat", {22'd0, dat_m2s}, {22'd0, d0});
                    chk("stable_we", {31'd0, we_m2s}, {31'd0, w0});
                    tx_adr.push_back(adr_m2s);
                    tx_dat.push_back({22'd0, dat_m2s});
                    tx_we.push_back({31'd0, we_m2s});
                    if (we_m2s) n_wr++;
                    if (kick_at_ref && we_m2s && adr_m2s == c_cr) begin
                        kick_req     = 1'b1;
                        slave_kicked = 1'b1;
                        kick_at_ref  = 1'b0;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin : main
        rst         = 1'b1;
        enable      = 1'b1;
        kick_req    = 1'b0;
        kick_at_ref = 1'b0;
        ws          = 1;
        dat_s2m     = 10'h050;
`ifdef WWDG_CTRL_EWI_CLR_EN
        wwdg_ewi    = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc_m2s}, 32'd0);
        chk("rst_stb", {31'd0, stb_m2s}, 32'd0);
        chk("rst_we", {31'd0, we_m2s}, 32'd0);
        chk("rst_adr", adr_m2s, 32'd0);
        chk("rst_dat", {22'd0, dat_m2s}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_refresh", {16'd0, refresh_cnt}, 32'd0);
        chk("rst_missed", {31'd0, missed_kick}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Start-up: CFG write, then arm write; heartbeat given before arming
        pulse_kick();
        for (int i = 0; i < 200 && !armed; i++) @(negedge clk);
        chk("armed", {31'd0, armed}, 32'd1);
        chk("startup_ntx", tx_adr.size(), 32'd2);
        chk("cfg_adr", tx_adr[0], c_cfg);
        chk("cfg_dat", tx_dat[0], 32'h07F);
        chk("cfg_we", tx_we[0], 32'd1);
        chk("arm_adr", tx_adr[1], c_cr);
        chk("arm_dat", tx_dat[1], 32'h0FF);

        // In-window poll with a pending kick -> refresh
        for (int i = 0; i < 100 && refresh_cnt != 16'd1; i++) @(negedge clk);
        chk("refresh1", {16'd0, refresh_cnt}, 32'd1);
        chk("poll_rd_we", tx_we[2], 32'd0);
        chk("poll_rd_adr", tx_adr[2], c_cr);
        chk("ref_adr", tx_adr[3], c_cr);
        chk("ref_dat", tx_dat[3], 32'h0FF);
        chk("missed_pre", {31'd0, missed_kick}, 32'd0);

        // In-window poll without a kick -> missed, no write
        for (int i = 0; i < 100 && !missed_kick; i++) @(negedge clk);
        chk("missed_set", {31'd0, missed_kick}, 32'd1);
        chk("missed_ntx", tx_adr.size(), 32'd5);
        repeat (60) @(negedge clk);
        chk("missed_sticky", {31'd0, missed_kick}, 32'd1);
        chk("missed_no_wr", n_wr, 32'd3);
        chk("missed_refresh", {16'd0, refresh_cnt}, 32'd1);

        // Kick coinciding with the refresh ack keeps the kick pending
        kick_at_ref = 1'b1;
        pulse_kick();
        for (int i = 0; i < 100 && refresh_cnt != 16'd2; i++) @(negedge clk);
        chk("refresh2", {16'd0, refresh_cnt}, 32'd2);
        for (int i = 0; i < 100 && refresh_cnt != 16'd3; i++) @(negedge clk);
        chk("refresh3_set_wins", {16'd0, refresh_cnt}, 32'd3);

        // Drop enable during a stalled read
        ws = 6;
        for (int i = 0; i < 100 && !(cyc_m2s && !we_m2s); i++) @(negedge clk);
        chk("rd_started", {31'd0, cyc_m2s && !we_m2s}, 32'd1);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("cyc_held", {31'd0, cyc_m2s}, 32'd1);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        chk("armed_kept", {31'd0, armed}, 32'd1);
        chk("last_is_rd", tx_we[tx_we.size()-1], 32'd0);
        nt = tx_adr.size();
        repeat (60) @(negedge clk);
        chk("idle_no_tx", tx_adr.size(), nt);
        chk("idle_cyc", {31'd0, cyc_m2s}, 32'd0);
        ws = 1;
        enable = 1'b1;
        for (int i = 0; i < 60 && tx_adr.size() == nt; i++) @(negedge clk);
        chk("reen_ntx", tx_adr.size(), nt + 1);
        chk("reen_rd_we", tx_we[tx_we.size()-1], 32'd0);
        chk("reen_rd_adr", tx_adr[tx_adr.size()-1], c_cr);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ws = 4;
        for (int i = 0; i < 100 && !(cyc_m2s && we_m2s); i++) @(negedge clk);
        chk("wr_started", {31'd0, cyc_m2s && we_m2s}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", {31'd0, cyc_m2s}, 32'd0);
        chk("arst_stb", {31'd0, stb_m2s}, 32'd0);
        chk("arst_we", {31'd0, we_m2s}, 32'd0);
        chk("arst_adr", adr_m2s, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_armed", {31'd0, armed}, 32'd0);
        chk("arst_refresh", {16'd0, refresh_cnt}, 32'd0);
        chk("arst_missed", {31'd0, missed_kick}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ws = 1;

`ifdef WWDG_CTRL_EWI_CLR_EN
        // Early-wakeup interrupt clear
        for (int i = 0; i < 200 && !armed; i++) @(negedge clk);
        chk("ewi_armed", {31'd0, armed}, 32'd1);
        chk("ewi_cnt_rst", {24'd0, ewi_cnt}, 32'd0);
        @(negedge clk);
        wwdg_ewi = 1'b1;
        repeat (2) @(negedge clk);
        wwdg_ewi = 1'b0;
        for (int i = 0; i < 100 && ewi_cnt != 8'd1; i++) @(negedge clk);
        chk("ewi_cnt", {24'd0, ewi_cnt}, 32'd1);
        chk("ewi_adr", tx_adr[tx_adr.size()-1], 32'h0110_0008);
        chk("ewi_dat", tx_dat[tx_dat.size()-1], 32'd0);
        chk("ewi_we", tx_we[tx_we.size()-1], 32'd1);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
